// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the multi-cycle core: CPU control states plus the
// state and owner encodings used by the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    // Control states of the multi-cycle core that stalls on memory acks.
    typedef enum logic [2:0] {
        CPU_FETCH     = 3'd0,
        CPU_DECODE    = 3'd1,
        CPU_EXECUTE   = 3'd2,
        CPU_MEMORY    = 3'd3,
        CPU_WRITEBACK = 3'd4
    } cpu_state_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Which requester currently owns the memory port.
    typedef enum logic [1:0] {
        OWN_IF  = 2'd0,
        OWN_LS  = 2'd1,
        OWN_DBG = 2'd2
    } owner_t;

    // Wait counter is sized for the largest legal WAIT_CYC (15).
    localparam int WAIT_CYC_MAX = 15;
    localparam int CNT_W        = 4;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational priority picker: DBG always wins; IF and LS alternate on
// contention using last_ls (LS wins unless it won the previous IF/LS grant).
module arb_prio_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  logic   dbg_req,
    input  logic   last_ls,
    output logic   grant_valid,
    output owner_t grant_owner
);

    // Select the winning requester from the current request levels.
    always_comb begin
        // NOTE: both outputs get a default before any branch so no path leaves
        // them unassigned, which would otherwise infer latches.
        grant_valid = 1'b0;
        grant_owner = OWN_IF;
        if (dbg_req) begin
            grant_valid = 1'b1;
            grant_owner = OWN_DBG;
        end else if (if_req && ls_req) begin
            grant_valid = 1'b1;
            grant_owner = last_ls ? OWN_IF : OWN_LS;
        end else if (ls_req) begin
            grant_valid = 1'b1;
            grant_owner = OWN_LS;
        end else if (if_req) begin
            grant_valid = 1'b1;
            grant_owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch, load/store
// and the debug loader. Each access holds mem_en for WAIT_CYC cycles, then the
// winner gets a one-cycle ack; the port always returns to IDLE before the next
// grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_ack,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                dbg_ack,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    arb_state_t       state;
    owner_t           owner;
    logic             last_ls;
    logic [CNT_W-1:0] wait_cnt;

    logic             grant_valid;
    owner_t           grant_owner;

    arb_prio_pick u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .dbg_req     (dbg_req),
        .last_ls     (last_ls),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Arbitration FSM: grant in IDLE, hold the latched access for WAIT_CYC
    // cycles in ACCESS, pulse the owner's ack in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            last_ls   <= 1'b0;
            wait_cnt  <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            dbg_ack   <= 1'b0;
            rd_data   <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            // NOTE: every register here uses <= so all of them update from the
            // same pre-edge values; the ack defaults below are then overridden
            // only in the cycle that enters RESP.
            if_ack  <= 1'b0;
            ls_ack  <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        state    <= ARB_ACCESS;
                        owner    <= grant_owner;
                        wait_cnt <= CNT_LOAD;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        case (grant_owner)
                            OWN_LS: begin
                                mem_we    <= ls_we;
                                mem_addr  <= ls_addr;
                                mem_wdata <= ls_wdata;
                                mem_be    <= ls_be;
                                last_ls   <= 1'b1;
                            end
                            OWN_DBG: begin
                                // Debug grants leave the IF/LS fairness bit alone.
                                mem_we    <= dbg_we;
                                mem_addr  <= dbg_addr;
                                mem_wdata <= dbg_wdata;
                                mem_be    <= '1;
                            end
                            default: begin
                                mem_we    <= 1'b0;
                                mem_addr  <= if_addr;
                                mem_wdata <= '0;
                                mem_be    <= '1;
                                last_ls   <= 1'b0;
                            end
                        endcase
                    end
                end
                ARB_ACCESS: begin
                    if (wait_cnt == '0) begin
                        // Read data is valid on the last wait cycle only.
                        if (!mem_we) begin
                            rd_data <= mem_rdata;
                        end
                        case (owner)
                            OWN_LS:  ls_ack  <= 1'b1;
                            OWN_DBG: dbg_ack <= 1'b1;
                            default: if_ack  <= 1'b1;
                        endcase
                        state     <= ARB_RESP;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions, hand-written
// arbitration/reset/ignore-input sequences, then randomized traffic checked
// against a transaction-level reference model with its own memory image.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int BE_W     = DATA_W / 8;
    localparam int WAIT_CYC = 2;
    localparam int N_RAND   = 1500;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, ls_req, ls_we, dbg_req, dbg_we;
    logic [ADDR_W-1:0] if_addr, ls_addr, dbg_addr;
    logic [DATA_W-1:0] ls_wdata, dbg_wdata;
    logic [BE_W-1:0]   ls_be;
    logic              if_ack, ls_ack, dbg_ack, busy;
    logic [DATA_W-1:0] rd_data;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_ack(ls_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rd_data(rd_data), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- memory macro and reference memory ----------------
    logic [31:0] bench_mem [int unsigned];
    logic [31:0] ref_mem   [int unsigned];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] bench_read(input logic [31:0] a);
        return bench_mem.exists(a >> 2) ? bench_mem[a >> 2] : mem_default(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : mem_default(a);
    endfunction

    // Memory macro: applies enabled writes, presents read data while enabled.
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) bench_mem[mem_addr >> 2] = merge_be(bench_read(mem_addr), mem_wdata, mem_be);
            mem_rdata <= bench_read(mem_addr);
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int who, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        case (who)
            0: begin if_req = req; if_addr = addr; end
            1: begin ls_req = req; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_be = be; end
            default: begin dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
        endcase
    endtask

    task automatic wait_ack(output int who, output int at);
        who = -1;
        at  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_ack || ls_ack || dbg_ack) begin
                who = if_ack ? 0 : (ls_ack ? 1 : 2);
                at  = cyc;
                return;
            end
        end
        check("ack_timeout", 64'(0), 64'(1));
    endtask

    typedef struct {
        int          own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  exp_be;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic run_txn(input vec_t v, input int idx);
        drive(v.own, 1'b1, v.we, v.addr, v.wdata, v.be);
        for (int k = 1; k <= WAIT_CYC; k++) begin
            @(negedge clk);
            check($sformatf("v%0d_en_c%0d", idx, k), 64'(mem_en), 64'(1));
            check($sformatf("v%0d_we_c%0d", idx, k), 64'(mem_we), 64'(v.we));
            check($sformatf("v%0d_addr_c%0d", idx, k), 64'(mem_addr), 64'(v.addr));
            check($sformatf("v%0d_be_c%0d", idx, k), 64'(mem_be), 64'(v.exp_be));
            if (v.we) check($sformatf("v%0d_wdata_c%0d", idx, k), 64'(mem_wdata), 64'(v.wdata));
            check($sformatf("v%0d_noack_c%0d", idx, k), 64'({dbg_ack, ls_ack, if_ack}), 64'(0));
        end
        @(negedge clk);
        check($sformatf("v%0d_ack", idx), 64'({dbg_ack, ls_ack, if_ack}), 64'(1 << v.own));
        check($sformatf("v%0d_en_resp", idx), 64'(mem_en), 64'(0));
        check($sformatf("v%0d_rd", idx), 64'(rd_data), 64'(v.exp_rd));
        drive(v.own, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'(0));
        check($sformatf("v%0d_idle_ack", idx), 64'({dbg_ack, ls_ack, if_ack}), 64'(0));
    endtask

    // ---------------- reference model state (random phase) ----------------
    typedef struct {
        bit          pend;
        bit          fly;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } rq_t;

    rq_t         rq [3];
    int          t, own, o;
    bit          m_last_ls;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, e_rd;
    logic [3:0]  m_be;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        int   who, at, r;
        int   order [4];

        rst = 1'b1;
        if_req = 0; ls_req = 0; dbg_req = 0; ls_we = 0; dbg_we = 0;
        if_addr = '0; ls_addr = '0; dbg_addr = '0; ls_wdata = '0; dbg_wdata = '0; ls_be = '0;
        bench_mem[32'h100 >> 2] = 32'hDEADBEEF;
        bench_mem[32'h200 >> 2] = 32'hAABBCCDD;

        vecs[0] = '{0, 1'b0, 32'h100, 32'h0,      4'hF,    4'hF,    32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 32'h200, 32'h12345678, 4'b0011, 4'b0011, 32'hDEADBEEF};
        vecs[2] = '{1, 1'b0, 32'h200, 32'h0,      4'hF,    4'hF,    32'hAABB5678};
        vecs[3] = '{2, 1'b1, 32'h040, 32'hCAFEF00D, 4'h0,  4'hF,    32'hAABB5678};
        vecs[4] = '{2, 1'b0, 32'h040, 32'h0,      4'h0,    4'hF,    32'hCAFEF00D};
        vecs[5] = '{0, 1'b0, 32'h040, 32'h0,      4'h0,    4'hF,    32'hCAFEF00D};
        vecs[6] = '{1, 1'b0, 32'h100, 32'h0,      4'b0100, 4'b0100, 32'hDEADBEEF};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_acks", 64'({dbg_ack, ls_ack, if_ack}), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Single transactions from IDLE.
        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

        // IF and LS held together from reset: LS, IF, LS, IF.
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        order = '{1, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            wait_ack(who, at);
            check($sformatf("alt_owner%0d", i), 64'(who), 64'(order[i]));
            check($sformatf("alt_time%0d", i), 64'(at), 64'(r + WAIT_CYC + 1 + i * (WAIT_CYC + 2)));
        end
        if_req = 0;
        ls_req = 0;
        @(negedge clk);

        // DBG raised mid-LS access with IF pending; LS re-requests after its ack.
        drive(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
        @(negedge clk);
        check("dbg_seq_ls_en", 64'(mem_en), 64'(1));
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        drive(2, 1'b1, 1'b0, 32'h28, 32'h0, 4'h0);
        order = '{1, 2, 0, 1};
        for (int i = 0; i < 4; i++) begin
            wait_ack(who, at);
            check($sformatf("dbg_seq_owner%0d", i), 64'(who), 64'(order[i]));
            if (who == 2) dbg_req = 0;
            if (who == 0) if_req = 0;
        end
        ls_req = 0;
        @(negedge clk);

        // Reset in the second ACCESS cycle of a store; held ls_req regranted.
        drive(1, 1'b1, 1'b1, 32'h80, 32'h55, 4'hF);
        @(negedge clk);
        check("rst_mid_en_c1", 64'(mem_en), 64'(1));
        @(negedge clk);
        check("rst_mid_we_c2", 64'(mem_we), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_mid_en_drop", 64'(mem_en), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_rd", 64'(rd_data), 64'(0));
        @(negedge clk);
        check("rst_mid_no_ack", 64'(ls_ack), 64'(0));
        rst = 1'b0;
        r = cyc;
        wait_ack(who, at);
        check("rst_regrant_owner", 64'(who), 64'(1));
        check("rst_regrant_time", 64'(at), 64'(r + WAIT_CYC + 1));
        ls_req = 0;
        @(negedge clk);

        // Request dropped and address changed after grant.
        drive(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'hFFF0, 32'h0, 4'hF);
        check("drop_addr_c1", 64'(mem_addr), 64'(32'h300));
        @(negedge clk);
        check("drop_addr_c2", 64'(mem_addr), 64'(32'h300));
        @(negedge clk);
        check("drop_ack", 64'(ls_ack), 64'(1));
        @(negedge clk);
        check("drop_ack_once", 64'(ls_ack), 64'(0));

        // Randomized traffic against the reference model.
        rst = 1'b1;
        if_req = 0; ls_req = 0; dbg_req = 0;
        for (int i = 0; i < 3; i++) rq[i] = '{0, 0, 1'b0, 32'h0, 32'h0, 4'h0};
        t = 0; own = 0; m_last_ls = 0; e_rd = '0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            if (c > 0) begin
                check("rnd_en", 64'(mem_en), 64'(t >= 1 && t <= WAIT_CYC));
                check("rnd_busy", 64'(busy), 64'(t != 0));
                check("rnd_ack", 64'({dbg_ack, ls_ack, if_ack}),
                      64'((t == WAIT_CYC + 1) ? (1 << own) : 0));
                check("rnd_rd", 64'(rd_data), 64'(e_rd));
                if (t >= 1 && t <= WAIT_CYC) begin
                    check("rnd_we", 64'(mem_we), 64'(m_we));
                    check("rnd_addr", 64'(mem_addr), 64'(m_addr));
                    check("rnd_be", 64'(mem_be), 64'(m_be));
                    if (m_we) check("rnd_wdata", 64'(mem_wdata), 64'(m_wdata));
                end else begin
                    check("rnd_idle_addr", 64'(mem_addr), 64'(0));
                    check("rnd_idle_we", 64'(mem_we), 64'(0));
                end
            end
            // Requesters: the owner is released by its ack; idle ones may issue new work.
            if (t == WAIT_CYC + 1) rq[own].fly = 0;
            for (int q = 0; q < 3; q++) begin
                if (!rq[q].pend && !rq[q].fly && ($urandom % 3 == 0)) begin
                    rq[q].pend  = 1;
                    rq[q].we    = (q == 0) ? 1'b0 : 1'($urandom % 2);
                    rq[q].addr  = 32'h1000 + 32'(($urandom % 16) * 4);
                    rq[q].wdata = $urandom;
                    rq[q].be    = 4'($urandom % 16);
                end
                if (rq[q].pend)
                    drive(q, 1'b1, rq[q].we, rq[q].addr, rq[q].wdata, rq[q].be);
                else
                    drive(q, rq[q].fly ? 1'($urandom % 2) : 1'b0, 1'($urandom % 2),
                          $urandom, $urandom, 4'($urandom % 16));
            end
            // Reference model: what the coming clock edge does.
            if (t == 0) begin
                if (dbg_req) o = 2;
                else if (if_req && ls_req) o = m_last_ls ? 0 : 1;
                else if (ls_req) o = 1;
                else if (if_req) o = 0;
                else o = -1;
                if (o >= 0) begin
                    own     = o;
                    m_we    = (o == 0) ? 1'b0 : rq[o].we;
                    m_addr  = rq[o].addr;
                    m_wdata = rq[o].wdata;
                    m_be    = (o == 1) ? rq[o].be : 4'hF;
                    if (o != 2) m_last_ls = (o == 1);
                    rq[o].pend = 0;
                    rq[o].fly  = 1;
                    t = 1;
                end
            end else if (t <= WAIT_CYC) begin
                if (t == WAIT_CYC) begin
                    if (m_we) ref_mem[m_addr >> 2] = merge_be(ref_read(m_addr), m_wdata, m_be);
                    else e_rd = ref_read(m_addr);
                end
                t++;
            end else begin
                t = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
